// File: rtl/alu_cmd_responder_if.sv
// Request/response channel bundle for alu_cmd_responder.
// The slave side is the responder; the master side is the initiator.
interface alu_cmd_responder_if #(
    parameter int N = 8
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [4:0]     cmd_op;
    logic [N-1:0]   cmd_num1;
    logic [N-1:0]   cmd_num2;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [N-1:0]   rsp_results;
    logic [2*N-1:0] rsp_xresults;
    logic           rsp_carry;
    logic           rsp_overflow;
    logic           rsp_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_num1, cmd_num2, rsp_ready,
        output cmd_ready, rsp_valid, rsp_results, rsp_xresults,
               rsp_carry, rsp_overflow, rsp_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_num1, cmd_num2, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_results, rsp_xresults,
               rsp_carry, rsp_overflow, rsp_err
    );
endinterface

// File: rtl/alu_cmd_responder.sv
// Sequential ALU command responder: single-cycle ops resolve at accept,
// MUL runs an N-step shift-add engine; results return over valid/ready.
module alu_cmd_responder #(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_cmd_responder_if.slave  bus
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000, OP_SUB  = 5'b00001, OP_INC  = 5'b00010,
        OP_DEC  = 5'b00011, OP_MUL  = 5'b00100, OP_OR   = 5'b00101,
        OP_AND  = 5'b00110, OP_XOR  = 5'b00111, OP_NOR  = 5'b01000,
        OP_NAND = 5'b01001, OP_XNOR = 5'b01010, OP_NOT  = 5'b01011,
        OP_LSL  = 5'b01100, OP_LSR  = 5'b01101, OP_ASR  = 5'b01110,
        OP_ROL  = 5'b01111, OP_ROR  = 5'b10000, OP_EQ   = 5'b10001,
        OP_GT   = 5'b10010, OP_LT   = 5'b10011, OP_GE   = 5'b10100,
        OP_LE   = 5'b10101
    } op_e;

    state_e         state_q, state_d;
    logic           cmd_ready_q, cmd_ready_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [N-1:0]   rsp_results_q, rsp_results_d;
    logic [2*N-1:0] rsp_xresults_q, rsp_xresults_d;
    logic           rsp_carry_q, rsp_carry_d;
    logic           rsp_overflow_q, rsp_overflow_d;
    logic           rsp_err_q, rsp_err_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Single-cycle ALU, evaluated straight from the command inputs
    logic [N-1:0]   a_w, b_w;
    logic [N:0]     sum_w, diff_w;
    logic [N-1:0]   alu_res;
    logic           alu_carry, alu_ovf, alu_err;
    logic [2*N-1:0] acc_next;

    assign a_w    = bus.cmd_num1;
    assign b_w    = bus.cmd_num2;
    assign sum_w  = {1'b0, a_w} + {1'b0, b_w};
    assign diff_w = {1'b0, a_w} - {1'b0, b_w};

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (bus.cmd_op)
            OP_ADD: begin
                alu_res   = sum_w[N-1:0];
                alu_carry = sum_w[N];
                alu_ovf   = (a_w[N-1] == b_w[N-1]) && (sum_w[N-1] != a_w[N-1]);
            end
            OP_SUB: begin
                alu_res   = diff_w[N-1:0];
                alu_carry = (a_w < b_w);
                alu_ovf   = (a_w[N-1] != b_w[N-1]) && (diff_w[N-1] != a_w[N-1]);
            end
            OP_INC: begin
                alu_res   = a_w + N'(1);
                alu_carry = &a_w;
                alu_ovf   = (a_w == {1'b0, {(N-1){1'b1}}});
            end
            OP_DEC: begin
                alu_res   = a_w - N'(1);
                alu_carry = (a_w == '0);
                alu_ovf   = (a_w == {1'b1, {(N-1){1'b0}}});
            end
            OP_MUL:  alu_res = '0;
            OP_OR:   alu_res = a_w | b_w;
            OP_AND:  alu_res = a_w & b_w;
            OP_XOR:  alu_res = a_w ^ b_w;
            OP_NOR:  alu_res = ~(a_w | b_w);
            OP_NAND: alu_res = ~(a_w & b_w);
            OP_XNOR: alu_res = ~(a_w ^ b_w);
            OP_NOT:  alu_res = ~a_w;
            OP_LSL: begin
                alu_res   = {a_w[N-2:0], 1'b0};
                alu_carry = a_w[N-1];
            end
            OP_LSR: begin
                alu_res   = {1'b0, a_w[N-1:1]};
                alu_carry = a_w[0];
            end
            OP_ASR: begin
                alu_res   = {a_w[N-1], a_w[N-1:1]};
                alu_carry = a_w[0];
            end
            OP_ROL: begin
                alu_res   = {a_w[N-2:0], a_w[N-1]};
                alu_carry = a_w[N-1];
            end
            OP_ROR: begin
                alu_res   = {a_w[0], a_w[N-1:1]};
                alu_carry = a_w[0];
            end
            OP_EQ: alu_res = {{(N-1){1'b0}}, (a_w == b_w)};
            OP_GT: alu_res = {{(N-1){1'b0}}, (a_w >  b_w)};
            OP_LT: alu_res = {{(N-1){1'b0}}, (a_w <  b_w)};
            OP_GE: alu_res = {{(N-1){1'b0}}, (a_w >= b_w)};
            OP_LE: alu_res = {{(N-1){1'b0}}, (a_w <= b_w)};
            default: alu_err = 1'b1;
        endcase
    end

    // One multiplier bit per EXEC cycle; mcand_q already carries the bit-index shift
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d        = state_q;
        cmd_ready_d    = cmd_ready_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_results_d  = rsp_results_q;
        rsp_xresults_d = rsp_xresults_q;
        rsp_carry_d    = rsp_carry_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_err_d      = rsp_err_q;
        mcand_d        = mcand_q;
        mplier_d       = mplier_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    mcand_d     = {{N{1'b0}}, a_w};
                    mplier_d    = b_w;
                    if (bus.cmd_op == OP_MUL) begin
                        state_d = ST_EXEC;
                        acc_d   = '0;
                        cnt_d   = CW'(N);
                    end else begin
                        state_d        = ST_RESP;
                        rsp_valid_d    = 1'b1;
                        rsp_results_d  = alu_res;
                        rsp_xresults_d = {{N{1'b0}}, alu_res};
                        rsp_carry_d    = alu_carry;
                        rsp_overflow_d = alu_ovf;
                        rsp_err_d      = alu_err;
                    end
                end
            end
            ST_EXEC: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d        = ST_RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_results_d  = acc_next[N-1:0];
                    rsp_xresults_d = acc_next;
                    rsp_carry_d    = |acc_next[2*N-1:N];
                    rsp_overflow_d = 1'b0;
                    rsp_err_d      = 1'b0;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cmd_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_results_q  <= '0;
            rsp_xresults_q <= '0;
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_err_q      <= 1'b0;
            mcand_q        <= '0;
            mplier_q       <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            cmd_ready_q    <= cmd_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_results_q  <= rsp_results_d;
            rsp_xresults_q <= rsp_xresults_d;
            rsp_carry_q    <= rsp_carry_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_err_q      <= rsp_err_d;
            mcand_q        <= mcand_d;
            mplier_q       <= mplier_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_results  = rsp_results_q;
    assign bus.rsp_xresults = rsp_xresults_q;
    assign bus.rsp_carry    = rsp_carry_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign bus.rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Scoreboard bench for alu_cmd_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_alu_cmd_responder;

    localparam int N = 8;

    typedef struct packed {
        logic [N-1:0]   r;
        logic [2*N-1:0] x;
        logic           c;
        logic           o;
        logic           e;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    alu_cmd_responder_if #(.N(N)) bus ();

    alu_cmd_responder #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [N-1:0] r, input logic c, input logic o, input logic e);
        exp_t t;
        t.r = r;
        t.x = {{N{1'b0}}, r};
        t.c = c;
        t.o = o;
        t.e = e;
        return t;
    endfunction

    function automatic exp_t mk_mul(input logic [2*N-1:0] x);
        exp_t t;
        t.r = x[N-1:0];
        t.x = x;
        t.c = |x[2*N-1:N];
        t.o = 1'b0;
        t.e = 1'b0;
        return t;
    endfunction

    // Monitor: one comparison set per response handshake
    always @(negedge clk) begin
        if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rsp: got results 0x%0h, expected no response", bus.rsp_results);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_results",  32'(bus.rsp_results),  32'(e.r));
                check("rsp_xresults", 32'(bus.rsp_xresults), 32'(e.x));
                check("rsp_carry",    32'(bus.rsp_carry),    32'(e.c));
                check("rsp_overflow", 32'(bus.rsp_overflow), 32'(e.o));
                check("rsp_err",      32'(bus.rsp_err),      32'(e.e));
            end
        end
    end

    // Inputs change just after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input exp_t e, input int lat);
        int edges;
        int guard;
        tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_num1  = a;
        bus.cmd_num2  = b;
        guard = 0;
        while (!bus.cmd_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
        exp_q.push_back(e);
        tick();
        bus.cmd_valid = 1'b0;
        edges = 1;
        while (!bus.rsp_valid && edges < 50) begin
            tick();
            edges++;
        end
        check("latency", 32'(edges), 32'(lat));
        tick();
        check("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
        check("cmd_ready_after_hs", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected simulation end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi_cnt;
        n_checks = 0;
        n_errors = 0;
        reset_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_num1  = '0;
        bus.cmd_num2  = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready",    32'(bus.cmd_ready),    32'd1);
        check("reset_rsp_valid",    32'(bus.rsp_valid),    32'd0);
        check("reset_rsp_results",  32'(bus.rsp_results),  32'd0);
        check("reset_rsp_xresults", 32'(bus.rsp_xresults), 32'd0);
        check("reset_rsp_flags",    32'({bus.rsp_carry, bus.rsp_overflow, bus.rsp_err}), 32'd0);
        reset_n = 1'b1;

        send(5'b00000, 8'd100, 8'd28,  mk(8'd128, 1'b0, 1'b1, 1'b0), 1);
        send(5'b00000, 8'd100, 8'd200, mk(8'd44,  1'b1, 1'b0, 1'b0), 1);
        send(5'b00001, 8'd20,  8'd30,  mk(8'd246, 1'b1, 1'b0, 1'b0), 1);
        send(5'b00010, 8'd127, 8'd0,   mk(8'd128, 1'b0, 1'b1, 1'b0), 1);
        send(5'b00011, 8'd0,   8'd0,   mk(8'd255, 1'b1, 1'b0, 1'b0), 1);
        send(5'b00100, 8'd10,  8'd20,  mk_mul(16'd200),   N + 1);
        send(5'b00100, 8'd255, 8'd255, mk_mul(16'd65025), N + 1);
        send(5'b01100, 8'b10010011, 8'd0, mk(8'b00100110, 1'b1, 1'b0, 1'b0), 1);
        send(5'b01101, 8'b10010011, 8'd0, mk(8'b01001001, 1'b1, 1'b0, 1'b0), 1);
        send(5'b01110, 8'b10010011, 8'd0, mk(8'b11001001, 1'b1, 1'b0, 1'b0), 1);
        send(5'b01111, 8'b10010011, 8'd0, mk(8'b00100111, 1'b1, 1'b0, 1'b0), 1);
        send(5'b10000, 8'b10010011, 8'd0, mk(8'b11001001, 1'b1, 1'b0, 1'b0), 1);
        send(5'b01010, 8'hF0,  8'h3C,  mk(8'h33, 1'b0, 1'b0, 1'b0), 1);
        send(5'b01011, 8'h5A,  8'h00,  mk(8'hA5, 1'b0, 1'b0, 1'b0), 1);
        send(5'b10100, 8'd25,  8'd25,  mk(8'd1,  1'b0, 1'b0, 1'b0), 1);
        send(5'b10011, 8'd3,   8'd200, mk(8'd1,  1'b0, 1'b0, 1'b0), 1);
        send(5'b11000, 8'd77,  8'd33,  mk(8'd0,  1'b0, 1'b0, 1'b1), 1);

        // Backpressure: response held while new commands wave at the input
        tick();
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 5'b00000;
        bus.cmd_num1  = 8'd3;
        bus.cmd_num2  = 8'd4;
        exp_q.push_back(mk(8'd7, 1'b0, 1'b0, 1'b0));
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid",    32'(bus.rsp_valid),    32'd1);
            check("bp_cmd_ready",    32'(bus.cmd_ready),    32'd0);
            check("bp_rsp_results",  32'(bus.rsp_results),  32'd7);
            check("bp_rsp_xresults", 32'(bus.rsp_xresults), 32'd7);
            bus.cmd_op   = (i == 4) ? 5'b00001 : 5'b00100;
            bus.cmd_num1 = (i == 4) ? 8'd10 : 8'(i + 50);
            bus.cmd_num2 = (i == 4) ? 8'd3  : 8'(i + 90);
            tick();
        end
        bus.rsp_ready = 1'b1;
        exp_q.push_back(mk(8'd7, 1'b0, 1'b0, 1'b0));
        tick();
        check("bp_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("bp_idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        check("bp_next_accepted", 32'(bus.rsp_valid), 32'd1);
        tick();
        check("bp_next_done", 32'(bus.rsp_valid), 32'd0);

        // Reset during the 4th EXEC cycle of a MUL
        tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 5'b00100;
        bus.cmd_num1  = 8'd7;
        bus.cmd_num2  = 8'd9;
        tick();
        bus.cmd_valid = 1'b0;
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_rsp_valid",    32'(bus.rsp_valid),    32'd0);
        check("rst_async_cmd_ready",    32'(bus.cmd_ready),    32'd1);
        check("rst_async_rsp_results",  32'(bus.rsp_results),  32'd0);
        check("rst_async_rsp_xresults", 32'(bus.rsp_xresults), 32'd0);
        check("rst_async_rsp_flags",    32'({bus.rsp_carry, bus.rsp_overflow, bus.rsp_err}), 32'd0);
        tick();
        reset_n = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.rsp_valid) hi_cnt++;
            tick();
        end
        check("rst_no_aborted_rsp", 32'(hi_cnt), 32'd0);
        send(5'b00000, 8'd1, 8'd1, mk(8'd2, 1'b0, 1'b0, 1'b0), 1);

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_responder.md
Name: alu_cmd_responder

Overview:
- Sequential command-responder front end for the N-bit ALU operation set, using the same 5-bit opcode map.
- Accepts one command (opcode, num1, num2) over a valid/ready request channel and executes it.
- MUL is computed by an N-cycle shift-add engine; all other operations take a single cycle.
- Returns the result over a valid/ready response channel, for use by bus-attached or CPU-side initiators.

Parameters:
N, 8, operand width in bits (N >= 2)

Ports:
clk  input  1  clock; all state changes on the rising edge
reset_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  responder can accept a command
cmd_op  input  5  opcode (ALU opcode map)
cmd_num1  input  N  operand a
cmd_num2  input  N  operand b
rsp_valid  output  1  response present
rsp_ready  input  1  initiator accepts the response
rsp_results  output  N  N-bit result
rsp_xresults  output  2N  wide result
rsp_carry  output  1  carry/borrow/shift-out flag
rsp_overflow  output  1  signed overflow flag
rsp_err  output  1  illegal opcode

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state IDLE; cmd_ready=1; rsp_valid=0; all rsp_* data and flags 0; internal operand, accumulator and counter registers 0.
- Reset mid-operation: the in-flight command is dropped and no response is issued.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: cmd_ready=1. A command is accepted on an edge where cmd_valid=1; the operands and opcode are registered at that edge.
  - Non-MUL opcode: result computed from cmd_* at the accept edge; next state RESP.
  - MUL (00100): next state EXEC; accumulator cleared; counter loaded with N.
  - EXEC: cmd_ready=0. Each edge processes one multiplier bit, LSB first: if the bit is 1, add a shifted left by the bit index into the 2N-bit accumulator. Counter decrements. On the edge where the counter reaches 0, go to RESP with results latched.
  - RESP: rsp_valid=1, cmd_ready=0. All rsp_* outputs are held stable until rsp_ready=1. On the handshake edge, go to IDLE and drop rsp_valid.
- Latency: accept at edge k.
  - Non-MUL: rsp_valid is high after edge k+1.
  - MUL: rsp_valid is high after edge k+N+1.
- Throughput: at most one command every 2 cycles. There is no accept in the same cycle as a response handshake.
- cmd_ready depends only on state, never on cmd_valid. cmd_* inputs are ignored outside IDLE.
- Operation definitions (a=num1, b=num2, unsigned unless noted):
  - Widths and defaults: rsp_xresults = zero-extended rsp_results for every op except MUL. rsp_carry and rsp_overflow are 0 unless listed.
  - 00000 ADD: a+b mod 2^N. carry = bit N of the sum. overflow = signed overflow (operands share a sign that differs from the result sign).
  - 00001 SUB: a-b mod 2^N. carry = borrow (a<b). overflow = signed overflow (operand signs differ and result sign differs from a).
  - 00010 INC: a+1. carry = (a all ones). overflow = (a == 0111..1).
  - 00011 DEC: a-1. carry = (a == 0). overflow = (a == 1000..0).
  - 00100 MUL: xresults = a*b, 2N bits. results = low N bits. carry = (upper N bits != 0).
  - Bitwise ops: 00101 OR, 00110 AND, 00111 XOR, 01000 NOR, 01001 NAND, 01010 XNOR, 01011 NOT a (b ignored).
  - Shifts by 1:
    - 01100 LSL: carry = a[N-1].
    - 01101 LSR: carry = a[0].
    - 01110 ASR: MSB replicated; carry = a[0].
    - 01111 ROL and 10000 ROR: carry = the bit rotated around.
  - Compares: 10001 EQ, 10010 GT, 10011 LT, 10100 GE, 10101 LE. Unsigned compare of a with b; results = {0..0, flag}.
  - 10110–11111: results=0, xresults=0, err=1. All other ops: err=0.
- Simultaneous events: a cmd_valid that arrives while in RESP is stalled until IDLE. The response channel has no skid buffer.

Test Plan:
- Reset, then ADD a=100, b=28 -> rsp_valid one cycle after accept; results=128, carry=0, overflow=1, err=0.
- ADD 100+200 -> results=44, carry=1, overflow=0.
- SUB 20-30 -> results=246, carry=1.
- MUL 10*20 -> rsp_valid exactly N+1=9 edges after accept; xresults=200, results=200, carry=0.
- MUL 255*255 -> xresults=65025, results=1, carry=1.
- Shift sweep with a=8'b10010011:
  - LSL -> 00100110, carry=1
  - LSR -> 01001001, carry=1
  - ASR -> 11001001
  - ROL -> 00100111
  - ROR -> 11001001
- Compare: GE 25,25 -> results=1.
- Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1 and changing cmd_* -> rsp_* stable, cmd_ready=0. On release: one handshake, IDLE for one cycle, then the next command is accepted.
- Illegal opcode 5'b11000 -> err=1, results=0, xresults=0.
- Reset mid-operation: assert reset_n=0 during the 4th EXEC cycle of a MUL -> all outputs are 0 immediately (asynchronously); after release, no response for the aborted MUL; a following ADD 1+1 returns 2.
